// File: rtl/isa_pkg.sv
// Shared definitions for the ISA DMA channel: FSM encoding, bus idle levels
// and transfer direction constants.
package isa_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ARMED  = 4'd1,
    ST_REQ    = 4'd2,
    ST_SETUP  = 4'd3,
    ST_STROBE = 4'd4,
    ST_HOLD   = 4'd5,
    ST_REL    = 4'd6
  } isa_state_e;

  localparam logic ISA_N_IDLE   = 1'b1;
  localparam logic ISA_AEN_IDLE = 1'b0;
  localparam logic DIR_WRITE    = 1'b0;
  localparam logic DIR_READ     = 1'b1;

  // DACK#/AEN/data are owned by the channel from SETUP through HOLD
  function automatic logic in_bus_cycle(input isa_state_e s);
    return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/isa_dma_channel_if.sv
// ISA-side signal bundle of one DMA channel: bus arbitration plus the
// DRQ/DACK pair, strobes, TC and the low data byte.
interface isa_dma_channel_if;
  logic       bus_req;
  logic       bus_gnt;
  logic       isa_drq;
  logic       isa_dack_n;
  logic       isa_aen;
  logic       isa_ior_n;
  logic       isa_iow_n;
  logic       isa_tc;
  logic [7:0] isa_d_out;
  logic       isa_d_oe;
  logic [7:0] isa_d_in;

  modport master (
    output bus_req, isa_dack_n, isa_aen, isa_ior_n, isa_iow_n, isa_tc,
           isa_d_out, isa_d_oe,
    input  bus_gnt, isa_drq, isa_d_in
  );

  modport slave (
    input  bus_req, isa_dack_n, isa_aen, isa_ior_n, isa_iow_n, isa_tc,
           isa_d_out, isa_d_oe,
    output bus_gnt, isa_drq, isa_d_in
  );
endinterface

// File: rtl/isa_byte_fifo.sv
// First-word-fall-through byte FIFO with valid/ready on both sides.
// in_ready stays low for the first clock after reset.
module isa_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        alive_q, full, empty, push, pop;

  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty     = (wptr_q == rptr_q);
  assign in_ready  = alive_q && !full;
  assign out_valid = !empty;
  assign out_data  = mem_q[rptr_q[AW-1:0]];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= in_data;
  end
endmodule

// File: rtl/isa_dma_channel.sv
// 8237-style single-transfer ISA DMA channel: one byte per bus ownership,
// host->card from the tx FIFO, card->host into the rx FIFO.
module isa_dma_channel
  import isa_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned SETUP_CYCLES  = 4,
  parameter int unsigned STROBE_CYCLES = 30,
  parameter int unsigned HOLD_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_dir,
  input  logic [15:0]       cfg_count,
  input  logic              cfg_autoinit,
  input  logic              cfg_abort,
  output logic              busy,
  output logic              done,
  output logic [15:0]       remaining,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  isa_dma_channel_if.master isa,
  output logic [3:0]        state_out
);
  localparam int unsigned TIMER_W = 8;
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] SETUP_LOAD  = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STROBE_LOAD = TIMER_W'(STROBE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);

  isa_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [15:0]        count_q, count_d, base_q;
  logic               dir_q, autoinit_q, abort_q, abort_d;
  logic               drq_p0, drq_p1, drq_s;
  logic [7:0]         tx_head, d_out_q;
  logic               tx_avail, rx_room, tx_pop, rx_push;
  logic               bus_req_q, dack_n_q, aen_q, ior_n_q, iow_n_q, tc_q, d_oe_q;
  logic               cyc_d;

  isa_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk, .reset_n,
    .in_data(tx_data), .in_valid(tx_valid), .in_ready(tx_ready),
    .out_data(tx_head), .out_valid(tx_avail), .out_ready(tx_pop)
  );

  isa_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk, .reset_n,
    .in_data(isa.isa_d_in), .in_valid(rx_push), .in_ready(rx_room),
    .out_data(rx_data), .out_valid(rx_valid), .out_ready(rx_ready)
  );

  // DRQ synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drq_p0 <= 1'b0;
      drq_p1 <= 1'b0;
    end else begin
      drq_p0 <= isa.isa_drq;
      drq_p1 <= drq_p0;
    end
  end
  assign drq_s = drq_p1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    abort_d = abort_q;
    done    = 1'b0;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    if (cfg_abort && in_bus_cycle(state_q)) abort_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (cfg_start) begin
          state_d = ST_ARMED;
          count_d = cfg_count;
        end
      end
      ST_ARMED, ST_REQ: begin
        if (cfg_abort) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (state_q == ST_ARMED) begin
          if (drq_s && ((dir_q == DIR_WRITE) ? tx_avail : rx_room)) state_d = ST_REQ;
        end else if (isa.bus_gnt) begin
          state_d = ST_SETUP;
          timer_d = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (timer_q == '0) begin
          state_d = ST_STROBE;
          timer_d = STROBE_LOAD;
        end else timer_d = timer_q - TIMER_ONE;
      end
      ST_STROBE: begin
        if (timer_q == '0) begin
          // FIFO moves as HOLD is entered; read data is sampled while IOR# is still low
          state_d = ST_HOLD;
          timer_d = HOLD_LOAD;
          tx_pop  = (dir_q == DIR_WRITE);
          rx_push = (dir_q == DIR_READ);
        end else timer_d = timer_q - TIMER_ONE;
      end
      ST_HOLD: begin
        if (timer_q == '0) state_d = ST_REL;
        else timer_d = timer_q - TIMER_ONE;
      end
      ST_REL: begin
        if (count_q != '0)  count_d = count_q - 16'd1;
        else if (autoinit_q) count_d = base_q;
        if (abort_q || cfg_abort || (count_q == '0 && !autoinit_q)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      count_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      abort_q <= abort_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && cfg_start) begin
      dir_q      <= cfg_dir;
      base_q     <= cfg_count;
      autoinit_q <= cfg_autoinit;
    end
  end

  // Bus pins are registered from the next state so they never glitch
  assign cyc_d = in_bus_cycle(state_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_req_q <= 1'b0;
      dack_n_q  <= ISA_N_IDLE;
      aen_q     <= ISA_AEN_IDLE;
      ior_n_q   <= ISA_N_IDLE;
      iow_n_q   <= ISA_N_IDLE;
      tc_q      <= 1'b0;
      d_oe_q    <= 1'b0;
      d_out_q   <= '0;
    end else begin
      bus_req_q <= cyc_d || (state_d == ST_REQ);
      dack_n_q  <= cyc_d ? ~ISA_N_IDLE : ISA_N_IDLE;
      aen_q     <= cyc_d ? ~ISA_AEN_IDLE : ISA_AEN_IDLE;
      iow_n_q   <= (state_d == ST_STROBE && dir_q == DIR_WRITE) ? ~ISA_N_IDLE : ISA_N_IDLE;
      ior_n_q   <= (state_d == ST_STROBE && dir_q == DIR_READ) ? ~ISA_N_IDLE : ISA_N_IDLE;
      tc_q      <= (state_d == ST_STROBE) && (count_d == '0);
      d_oe_q    <= cyc_d && (dir_q == DIR_WRITE);
      if (state_q == ST_REQ && state_d == ST_SETUP) d_out_q <= tx_head;
    end
  end

  assign isa.bus_req    = bus_req_q;
  assign isa.isa_dack_n = dack_n_q;
  assign isa.isa_aen    = aen_q;
  assign isa.isa_ior_n  = ior_n_q;
  assign isa.isa_iow_n  = iow_n_q;
  assign isa.isa_tc     = tc_q;
  assign isa.isa_d_oe   = d_oe_q;
  assign isa.isa_d_out  = d_out_q;

  assign busy      = (state_q != ST_IDLE);
  assign remaining = count_q;
  assign state_out = state_q;
endmodule

// File: tb/tb_isa_dma_channel.sv
// Directed bench for isa_dma_channel: write/read transfers, autoinit, FIFO
// underrun, abort and asynchronous reset during a strobe.
module tb_isa_dma_channel;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0, cfg_dir = 1'b0, cfg_autoinit = 1'b0, cfg_abort = 1'b0;
  logic [15:0] cfg_count = '0;
  logic        busy, done;
  logic [15:0] remaining;
  logic [7:0]  tx_data = '0, rx_data;
  logic        tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
  logic        drq = 1'b0;
  logic [7:0]  card_d = '0;
  logic [3:0]  state_out;

  int n_cmp = 0, n_fail = 0;

  isa_dma_channel_if isa_if ();
  assign isa_if.bus_gnt  = isa_if.bus_req;
  assign isa_if.isa_drq  = drq;
  assign isa_if.isa_d_in = card_d;

  isa_dma_channel dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_count(cfg_count),
    .cfg_autoinit(cfg_autoinit), .cfg_abort(cfg_abort),
    .busy(busy), .done(done), .remaining(remaining),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .isa(isa_if), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Strobe pulse recorder
  int          np = 0, n_done = 0, tc_cyc = 0, low_cnt = 0;
  logic [3:0]  done_state = '0;
  int          pw [32];
  logic [7:0]  pd [32];
  logic        ptc [32];
  logic        prd [32];
  logic [15:0] prem [32];
  logic [7:0]  cur_d;
  logic        cur_tc, cur_rd;
  logic [15:0] cur_rem;

  always @(negedge clk) begin
    if (!reset_n) low_cnt = 0;
    else begin
      if (done) begin n_done++; done_state = state_out; end
      if (isa_if.isa_tc) tc_cyc++;
      if (!isa_if.isa_iow_n || !isa_if.isa_ior_n) begin
        if (low_cnt == 0) begin
          cur_d = isa_if.isa_d_out; cur_tc = isa_if.isa_tc;
          cur_rd = !isa_if.isa_ior_n; cur_rem = remaining;
        end
        low_cnt++;
      end else if (low_cnt != 0) begin
        if (np < 32) begin
          pw[np] = low_cnt; pd[np] = cur_d; ptc[np] = cur_tc;
          prd[np] = cur_rd; prem[np] = cur_rem;
        end
        np++;
        low_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
  endtask

  task automatic start(input logic dir, input logic [15:0] cnt, input logic ai);
    cfg_dir = dir; cfg_count = cnt; cfg_autoinit = ai; cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    int k = 0;
    while (np < target && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    int k = 0;
    @(negedge clk);
    while (isa_if.isa_iow_n && isa_if.isa_ior_n && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  initial begin
    int p0, d0, t0, lat, any_req;
    int exp_rem [5];
    logic [7:0] exp_dat [3];
    exp_rem = '{1, 0, 1, 0, 1};
    exp_dat = '{8'hA1, 8'hB2, 8'hC3};

    // Reset values
    tick(2);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_remaining", 32'(remaining), 0);
    check("rst_bus_req", 32'(isa_if.bus_req), 0);
    check("rst_dack_n", 32'(isa_if.isa_dack_n), 1);
    check("rst_aen", 32'(isa_if.isa_aen), 0);
    check("rst_ior_n", 32'(isa_if.isa_ior_n), 1);
    check("rst_iow_n", 32'(isa_if.isa_iow_n), 1);
    check("rst_tc", 32'(isa_if.isa_tc), 0);
    check("rst_d_oe", 32'(isa_if.isa_d_oe), 0);
    check("rst_d_out", 32'(isa_if.isa_d_out), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_state", 32'(state_out), 0);
    reset_n = 1'b1;
    tick(2);
    check("tx_ready_after_rst", 32'(tx_ready), 1);

    // Host->card, three bytes
    push_tx(8'hA1); push_tx(8'hB2); push_tx(8'hC3);
    drq = 1'b1;
    tick(3);
    p0 = np; d0 = n_done; t0 = tc_cyc;
    start(1'b0, 16'd2, 1'b0);
    wait_idle("t1_idle", 400);
    check("t1_pulses", 32'(np - p0), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_width%0d", i), 32'(pw[p0+i]), 30);
      check($sformatf("t1_data%0d", i), 32'(pd[p0+i]), 32'(exp_dat[i]));
      check($sformatf("t1_tc%0d", i), 32'(ptc[p0+i]), (i == 2) ? 32'd1 : 32'd0);
    end
    check("t1_tc_cycles", 32'(tc_cyc - t0), 30);
    check("t1_done", 32'(n_done - d0), 1);
    check("t1_busy", 32'(busy), 0);
    check("t1_remaining", 32'(remaining), 0);

    // Card->host, single byte
    card_d = 8'h5A;
    p0 = np; d0 = n_done;
    start(1'b1, 16'd0, 1'b0);
    wait_idle("t2_idle", 200);
    check("t2_pulses", 32'(np - p0), 1);
    check("t2_is_read", 32'(prd[p0]), 1);
    check("t2_width", 32'(pw[p0]), 30);
    check("t2_tc", 32'(ptc[p0]), 1);
    check("t2_rx_valid", 32'(rx_valid), 1);
    check("t2_rx_data", 32'(rx_data), 32'h5A);
    check("t2_remaining", 32'(remaining), 0);
    check("t2_done", 32'(n_done - d0), 1);
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    @(negedge clk);
    check("t2_rx_drained", 32'(rx_valid), 0);

    // Autoinit, count=1, five transfers limited by five tx bytes
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33); push_tx(8'h44); push_tx(8'h55);
    p0 = np; d0 = n_done;
    start(1'b0, 16'd1, 1'b1);
    wait_pulses("t3_wait", p0 + 5, 1000);
    tick(10);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_tc%0d", i), 32'(ptc[p0+i]), (i == 1 || i == 3) ? 32'd1 : 32'd0);
      check($sformatf("t3_rem%0d", i), 32'(prem[p0+i]), 32'(exp_rem[i]));
    end
    check("t3_no_done", 32'(n_done - d0), 0);
    check("t3_busy", 32'(busy), 1);
    check("t3_remaining", 32'(remaining), 0);
    check("t3_state_armed", 32'(state_out), 1);

    // Underrun: DRQ high, tx empty
    any_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (isa_if.bus_req) any_req = 1;
    end
    check("t4_no_req", 32'(any_req), 0);
    @(posedge clk); #1;
    p0 = np;
    tx_data = 8'h77; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (!isa_if.isa_dack_n) break;
      @(posedge clk); #1;
      lat++;
    end
    check("t4_dack_latency", 32'(lat), 3);
    check("t4_d_oe", 32'(isa_if.isa_d_oe), 1);
    check("t4_aen", 32'(isa_if.isa_aen), 1);
    wait_pulses("t4_wait", p0 + 1, 200);
    check("t4_data", 32'(pd[p0]), 32'h77);
    check("t4_tc", 32'(ptc[p0]), 1);
    tick(10);
    check("t4_reload", 32'(remaining), 1);
    cfg_abort = 1'b1;
    @(negedge clk);
    check("t4_abort_done", 32'(done), 1);
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    @(negedge clk);
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_req", 32'(isa_if.bus_req), 0);

    // Abort during STROBE
    push_tx(8'hD4); push_tx(8'hE5);
    p0 = np; d0 = n_done;
    start(1'b0, 16'd5, 1'b0);
    wait_strobe("t5_strobe", 100);
    tick(5);
    cfg_abort = 1'b1; tick(1); cfg_abort = 1'b0;
    wait_idle("t5_idle", 200);
    check("t5_width", 32'(pw[p0]), 30);
    check("t5_done", 32'(n_done - d0), 1);
    check("t5_done_in_rel", 32'(done_state), 6);
    check("t5_remaining", 32'(remaining), 4);
    tick(20);
    check("t5_no_more_pulses", 32'(np - p0), 1);
    check("t5_no_req", 32'(isa_if.bus_req), 0);

    // Asynchronous reset during STROBE
    start(1'b0, 16'd3, 1'b0);
    wait_strobe("t6_strobe", 100);
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_iow_n", 32'(isa_if.isa_iow_n), 1);
    check("t6_dack_n", 32'(isa_if.isa_dack_n), 1);
    check("t6_aen", 32'(isa_if.isa_aen), 0);
    check("t6_bus_req", 32'(isa_if.bus_req), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_state", 32'(state_out), 0);
    check("t6_remaining", 32'(remaining), 0);
    check("t6_d_oe", 32'(isa_if.isa_d_oe), 0);
    check("t6_d_out", 32'(isa_if.isa_d_out), 0);
    check("t6_tx_ready", 32'(tx_ready), 0);
    check("t6_done", 32'(done), 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
